// File: rtl/spislave_pkg.sv
// spislave_pkg
// Shared types and helpers for the oversampled SPI slave with FIFOs.
//   spi_mode_t        : the four SPI modes, encoded as {CPOL, CPHA}
//   sample_on_rising  : 1 when the mode samples MOSI on the rising SCK edge
//   level_w           : width of a FIFO occupancy count for a given depth
package spislave_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rising(input spi_mode_t mode);
        logic rise;
        case (mode)
            MODE0, MODE3: rise = 1'b1;
            default:      rise = 1'b0;
        endcase
        return rise;
    endfunction

    // An occupancy count must be able to hold DEPTH itself, hence the +1.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spislave_sfifo.sv
// spislave_sfifo
// Synchronous FIFO, first-word-fall-through: rd_data_o always shows the
// stored head entry while the FIFO is not empty.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   push_i          write request (wr_data_i is stored when accepted)
//   wr_data_i       data to store
//   pop_i           read request (head is consumed when not empty)
//   rd_data_o       head entry
//   full_o          DEPTH entries stored
//   empty_o         no entries stored
//   level_o         occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle,
// which keeps the level unchanged. A pop while empty is ignored.
module spislave_sfifo
    import spislave_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = level_w(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_LVL);
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/spislave_fifo.sv
// spislave_fifo
// SPI slave, any word width (2..32) and any of the four SPI modes, with the
// SCK/SS/SDI pins oversampled in the clk domain (clk >= 8x SCK). Each
// direction is buffered by a spislave_sfifo; the host side uses valid/ready.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   sck, ss, sdi          SPI pins from the master (asynchronous)
//   sdo                   MISO, 0 outside a frame
//   tx_data/valid/ready   host -> TX FIFO push handshake
//   rx_data/valid/ready   RX FIFO head -> host pop handshake
//   tx_level, rx_level    FIFO occupancies
//   tx_underrun           sticky: a word was loaded from an empty TX FIFO
//   rx_overrun            sticky: a received word was dropped, RX FIFO full
//   flag_clr              clears both sticky flags (a same-cycle set wins)
//   busy                  a frame is in progress
// Build option: define SPISLAVE_LSB_FIRST_EN to run both directions
// LSB-first; by default words go MSB-first.
//
// Frame tracking
//   active_q | meaning
//   0        | idle: sdo low, SCK edges ignored, waiting for an SS fall
//   1        | in frame: SCK edges sample/shift, words complete every DATA_W
module spislave_fifo
    import spislave_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter logic [31:0] TX_IDLE    = 32'h0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sck,
    input  logic                           ss,
    input  logic                           sdi,
    output logic                           sdo,
    input  logic [DATA_W-1:0]              tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    output logic [DATA_W-1:0]              rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic [level_w(FIFO_DEPTH)-1:0] tx_level,
    output logic [level_w(FIFO_DEPTH)-1:0] rx_level,
    output logic                           tx_underrun,
    output logic                           rx_overrun,
    input  logic                           flag_clr,
    output logic                           busy
);

    localparam int                CNT_W       = $clog2(DATA_W + 1);
    localparam spi_mode_t         MODE        = spi_mode_t'({CPOL, CPHA});
    localparam bit                SAMPLE_RISE = sample_on_rising(MODE);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] IDLE_WORD   = TX_IDLE[DATA_W-1:0];

    logic sck_m_q, sck_s_q, sck_p_q;
    logic ss_m_q, ss_s_q, ss_p_q;
    logic sdi_m_q, sdi_s_q;

    logic sck_rise, sck_fall, ss_fall, ss_rise;
    logic sample_edge, shift_edge;

    logic              active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              first_q, first_d;
    logic              reload_q, reload_d;
    logic              underrun_q, overrun_q;

    logic [DATA_W-1:0] rx_next, tx_shifted;
    logic              tx_load, rx_push;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [DATA_W-1:0] tx_head;
    logic              sdo_bit;
    logic              underrun_set, overrun_set;

    // SS synchronisers come out of reset low so a select held across reset
    // never looks like a fall; only a fresh high-to-low transition starts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_m_q <= CPOL;
            sck_s_q <= CPOL;
            sck_p_q <= CPOL;
            ss_m_q  <= 1'b0;
            ss_s_q  <= 1'b0;
            ss_p_q  <= 1'b0;
            sdi_m_q <= 1'b0;
            sdi_s_q <= 1'b0;
        end else begin
            sck_m_q <= sck;
            sck_s_q <= sck_m_q;
            sck_p_q <= sck_s_q;
            ss_m_q  <= ss;
            ss_s_q  <= ss_m_q;
            ss_p_q  <= ss_s_q;
            sdi_m_q <= sdi;
            sdi_s_q <= sdi_m_q;
        end
    end

    assign sck_rise    = sck_s_q && !sck_p_q;
    assign sck_fall    = !sck_s_q && sck_p_q;
    assign ss_fall     = !ss_s_q && ss_p_q;
    assign ss_rise     = ss_s_q && !ss_p_q;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

`ifdef SPISLAVE_LSB_FIRST_EN
    assign rx_next    = {sdi_s_q, rx_sh_q[DATA_W-1:1]};
    assign tx_shifted = {1'b0, tx_sh_q[DATA_W-1:1]};
    assign sdo_bit    = tx_sh_q[0];
`else
    assign rx_next    = {rx_sh_q[DATA_W-2:0], sdi_s_q};
    assign tx_shifted = {tx_sh_q[DATA_W-2:0], 1'b0};
    assign sdo_bit    = tx_sh_q[DATA_W-1];
`endif

    // first_q: CPHA=1 word whose first shift edge only presents the already
    // loaded MSB. reload_q: a word just completed, so the next shift edge
    // fetches the following TX word instead of shifting.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        first_d  = first_q;
        reload_d = reload_q;
        tx_load  = 1'b0;
        rx_push  = 1'b0;
        if (ss_fall) begin
            active_d = 1'b1;
            cnt_d    = '0;
            rx_sh_d  = '0;
            first_d  = CPHA;
            reload_d = 1'b0;
            tx_load  = 1'b1;
        end else if (ss_rise) begin
            active_d = 1'b0;
            cnt_d    = '0;
            first_d  = 1'b0;
            reload_d = 1'b0;
        end else if (active_q) begin
            if (sample_edge) begin
                rx_sh_d = rx_next;
                if (cnt_q == LAST_BIT) begin
                    cnt_d    = '0;
                    rx_push  = 1'b1;
                    reload_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (shift_edge) begin
                if (reload_q) begin
                    tx_load  = 1'b1;
                    reload_d = 1'b0;
                    first_d  = 1'b0;
                end else if (first_q) begin
                    first_d = 1'b0;
                end else begin
                    tx_sh_d = tx_shifted;
                end
            end
        end
        if (tx_load) tx_sh_d = tx_empty ? IDLE_WORD : tx_head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            first_q  <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            first_q  <= first_d;
            reload_q <= reload_d;
        end
    end

    // A full RX FIFO still takes the word if the host pops in the same cycle.
    assign underrun_set = tx_load && tx_empty;
    assign overrun_set  = rx_push && rx_full && !rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= underrun_set || (underrun_q && !flag_clr);
            overrun_q  <= overrun_set || (overrun_q && !flag_clr);
        end
    end

    spislave_sfifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (tx_valid),
        .wr_data_i (tx_data),
        .pop_i     (tx_load),
        .rd_data_o (tx_head),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .level_o   (tx_level)
    );

    spislave_sfifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (rx_push),
        .wr_data_i (rx_next),
        .pop_i     (rx_ready),
        .rd_data_o (rx_data),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .level_o   (rx_level)
    );

    assign sdo         = active_q && sdo_bit;
    assign tx_ready    = !tx_full;
    assign rx_valid    = !rx_empty;
    assign tx_underrun = underrun_q;
    assign rx_overrun  = overrun_q;
    assign busy        = active_q;

endmodule

// File: doc/spislave_fifo.md
Name: spislave_fifo

Overview:
- Parametrised successor to the single-byte SPI slave, generalised to any word width and all four SPI modes.
- The SPI pins are oversampled in the system clock domain.
- Each direction is buffered by a FIFO, and the host logic uses valid/ready handshakes on both sides.
- Sits between the external SPI master (MIDI-Router host MCU) and the internal message routing logic.

Parameters:
- DATA_W, 8: bits per SPI word (2..32).
- FIFO_DEPTH, 4: entries per FIFO; power of 2, at least 2.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- TX_IDLE, 0: word shifted out when the TX FIFO is empty.

Ports:
- clk  in  1  system clock; must be at least 8x SCK.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock (asynchronous).
- ss  in  1  slave select, active low (asynchronous).
- sdi  in  1  MOSI (asynchronous).
- sdo  out  1  MISO; driven 0 while ss is high.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  TX push request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_W  head of the RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  RX pop request.
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX occupancy.
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX occupancy.
- tx_underrun  out  1  sticky flag: a word was loaded from an empty TX FIFO.
- rx_overrun  out  1  sticky flag: a received word was dropped because the RX FIFO was full.
- flag_clr  in  1  clears both sticky flags.
- busy  out  1  synchronised ss is low.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - both FIFOs empty, so tx_ready=1, rx_valid=0, levels=0;
  - flags=0, busy=0, sdo=0;
  - bit counter=0, shift register=0.
  Reset mid-frame aborts the frame. The next word is only accepted after a fresh ss falling edge.
- Input synchronisation and edge detection:
  - sck, ss and sdi each pass through a 2-FF synchroniser.
  - Edge detect compares the synchronised value with its previous value.
  - A pin transition is acted on 3 clk after it occurs.
- Edge classification:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - The sample edge is the leading edge if CPHA=0, the trailing edge if CPHA=1. The other edge is the shift edge.
- Frame start (synchronised ss falls):
  - Bit counter is cleared.
  - Shift register loads the TX FIFO head, which is popped.
  - If the TX FIFO is empty, TX_IDLE is loaded instead and tx_underrun is set.
  - sdo = shift MSB from the next cycle, so the first bit is valid before the first SCK edge in CPHA=0.
- Shift edge:
  - In CPHA=1, the first shift edge of each word only presents the MSB. It does not shift.
  - Every other shift edge presents the next bit on sdo.
- Sample edge:
  - The synchronised sdi enters the receive register LSB-side (MSB-first on the wire).
  - The bit counter increments.
- Word complete (counter reaches DATA_W):
  - The receive word is pushed into the RX FIFO in the same cycle, so rx_valid rises 1 clk later.
  - If the RX FIFO is full, the word is dropped and rx_overrun is set.
  - The counter wraps to 0.
  - The next TX word (or TX_IDLE) loads on the next shift edge, giving back-to-back words under one ss. It is valid on sdo before the next sample edge.
- Frame end (ss rises mid-word):
  - Partial receive bits are discarded, with no push.
  - The counter is cleared and sdo returns to 0.
  - A popped TX word is consumed and is not restored.
- FIFOs:
  - Push when valid and not full; pop when ready and not empty.
  - A simultaneous push and pop on a full or empty FIFO is legal: the level is unchanged when full. When empty, the push succeeds and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH. rx_data is the registered head (first-word-fall-through).
- Sticky flags:
  - Set on the event and held until flag_clr.
  - Set wins over a simultaneous flag_clr.

Optional Feature:
SPISLAVE_LSB_FIRST_EN.
- Defined: both directions run LSB-first. sdo presents shift[0] and shifts right; received bits enter at the MSB and shift right.
- Undefined: MSB-first as described above.

Decomposition:
- Package spislave_pkg:
  - spi_mode_t enum {MODE0..MODE3} with a helper function returning the sample-edge polarity from CPOL/CPHA;
  - the level-width localparam function.
- One sub-module, spislave_sfifo: the synchronous FIFO parametrised by width and depth, instantiated twice.

Test Plan:
1. Mode 0, DATA_W=8. Push 0xDE into TX, then run one frame with master sending 0xDE → master receives 0xDE; rx_data=0xDE; rx_valid=1; tx_level=0.
2. Empty TX FIFO, one frame sending 0x5A → master receives 0x00 (TX_IDLE); tx_underrun=1. After flag_clr → 0.
3. Five frames with rx_ready=0, FIFO_DEPTH=4, sending 0x01..0x05 → rx_level=4; pops return 0x01..0x04; rx_overrun=1.
4. ss deasserted after 3 bits, then a full frame sending 0x3C → only 0x3C is pushed; rx_level=1.
5. CPOL=1, CPHA=1, two words 0xA5 and 0x3C under one ss, TX preloaded with 0x11 and 0x22 → RX holds 0xA5 then 0x3C; master receives 0x11 then 0x22.
6. rst pulse mid-frame after 4 bits → all outputs at reset values. The next frame sending 0x81 receives 0x81.
